// File: rtl/lc3b_mem_sequencer.sv
// lc3b_mem_sequencer
//
// Multi-cycle memory-access sequencer for the LC-3b datapath. Runs LDR, STR,
// LDB, STB, LDI and STI against a single-port handshake memory, including
// byte-lane steering and the pointer read for indirect accesses. Any other
// opcode completes immediately with no memory traffic.
//
// Optional feature: define LC3B_MEM_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES cycles without mem_resp (done and err pulse together).
// Without the macro the block waits indefinitely and err is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles to wait for mem_resp (1..255), timeout build only
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   start, opcode, addr,    request pulse plus operands, sampled in IDLE
//   store_data
//   busy, done, err         status: not idle / completion pulse / abort pulse
//   load_data               load result, held until the next load completes
//   mem_address, mem_read,  memory request, held until mem_resp
//   mem_write, mem_wdata,
//   mem_wmask
//   mem_rdata, mem_resp     memory read data / completion
module lc3b_mem_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [15:0] addr,
  input  logic [15:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] load_data,
  output logic [15:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wmask,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PTR    = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  logic [1:0]  state;
  logic [3:0]  op_q;
  logic        addr_lsb_q;
  logic [15:0] sdata_q;
  logic [15:0] ptr_q;

  logic [3:0]  req_op;
  logic [15:0] req_ea;
  logic [15:0] req_sd;
  logic        req_byte;
  logic        req_store;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_wmask;

  logic        start_indirect;
  logic        start_direct;
  logic        outstanding;
  logic        issue_now;
  logic        timeout_hit;
  logic        abort;
  logic        load_op;
  logic [15:0] ld_value;

  assign start_indirect = (opcode == OP_LDI) || (opcode == OP_STI);
  assign start_direct   = (opcode == OP_LDR) || (opcode == OP_STR) ||
                          (opcode == OP_LDB) || (opcode == OP_STB);
  assign outstanding    = mem_read || mem_write;
  assign issue_now      = ((state == S_IDLE) && start && (start_direct || start_indirect)) ||
                          ((state == S_ACCESS) && !outstanding);
  assign abort          = outstanding && !mem_resp && timeout_hit;

  // Final-access request fields. In IDLE they come straight from the inputs
  // (direct access issued on the start edge); afterwards from the captured
  // operands with the pointer as effective address (indirect second access).
  always_comb begin
    req_op = op_q;
    req_ea = ptr_q;
    req_sd = sdata_q;
    if (state == S_IDLE) begin
      req_op = opcode;
      req_ea = addr;
      req_sd = store_data;
    end
    req_byte  = (req_op == OP_LDB) || (req_op == OP_STB);
    req_store = (req_op == OP_STB) || (req_op == OP_STR) || (req_op == OP_STI);
    req_addr  = req_byte ? req_ea : {req_ea[15:1], 1'b0};
    req_wdata = '0;
    req_wmask = '0;
    if (req_store) begin
      if (req_byte) begin
        req_wdata = {req_sd[7:0], req_sd[7:0]};
        req_wmask = req_ea[0] ? 2'b10 : 2'b01;
      end else begin
        req_wdata = req_sd;
        req_wmask = 2'b11;
      end
    end
  end

  assign load_op  = (op_q == OP_LDB) || (op_q == OP_LDR) || (op_q == OP_LDI);
  assign ld_value = (op_q == OP_LDB) ?
                    {8'h00, (addr_lsb_q ? mem_rdata[15:8] : mem_rdata[7:0])} :
                    mem_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      op_q        <= '0;
      addr_lsb_q  <= 1'b0;
      sdata_q     <= '0;
      ptr_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_data   <= '0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q       <= opcode;
            addr_lsb_q <= addr[0];
            sdata_q    <= store_data;
            busy       <= 1'b1;
            if (start_indirect) begin
              state       <= S_PTR;
              mem_read    <= 1'b1;
              mem_write   <= 1'b0;
              mem_address <= {addr[15:1], 1'b0};
              mem_wdata   <= '0;
              mem_wmask   <= '0;
            end else if (start_direct) begin
              state       <= S_ACCESS;
              mem_read    <= !req_store;
              mem_write   <= req_store;
              mem_address <= req_addr;
              mem_wdata   <= req_wdata;
              mem_wmask   <= req_wmask;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_PTR: begin
          if (mem_resp) begin
            // Strobes go low for one cycle; ACCESS issues from ptr_q next.
            ptr_q       <= mem_rdata;
            state       <= S_ACCESS;
            mem_read    <= 1'b0;
            mem_address <= '0;
          end else if (abort) begin
            state       <= S_DONE;
            done        <= 1'b1;
            mem_read    <= 1'b0;
            mem_address <= '0;
          end
        end

        S_ACCESS: begin
          if (!outstanding) begin
            mem_read    <= !req_store;
            mem_write   <= req_store;
            mem_address <= req_addr;
            mem_wdata   <= req_wdata;
            mem_wmask   <= req_wmask;
          end else if (mem_resp || abort) begin
            if (mem_resp && load_op) begin
              load_data <= ld_value;
            end
            state       <= S_DONE;
            done        <= 1'b1;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LC3B_MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;
  logic       err_q;

  // wait_cnt holds the number of completed waiting cycles of the current
  // request, so the abort fires on the edge that ends cycle TIMEOUT_CYCLES.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= abort;
      if (issue_now) begin
        wait_cnt <= '0;
      end else if (outstanding && !mem_resp) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  assign timeout_hit = (wait_cnt == TO_LAST);
  assign err         = err_q;
`else
  // TIMEOUT_CYCLES has no effect in this build.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0) || issue_now;
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

endmodule
